// File: rtl/branch_pipe.sv
// Branch execution unit: resolves relative/absolute/conditional branches, checks the fetch
// prediction, and delivers writeback and redirect records after LAT cycles.
module branch_pipe #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned LAT        = 1,
    parameter int unsigned SQUASH_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [8:0]        opcode9,
    input  logic [15:0]       immediate16,
    input  logic [0:127]      rt,
    input  logic [6:0]        addr_rt,
    input  logic [PC_W-1:0]   PCin,
    input  logic              predictIn,
    input  logic [PC_W-1:0]   predictPCin,
    input  logic              flush,
    output logic [0:138]      pipe,
    output logic [0:2*PC_W+1] PCpipe,
    output logic              out_valid,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mp_cnt
);

    localparam logic [8:0] OpBr    = 9'b001100100;
    localparam logic [8:0] OpBrsl  = 9'b001100110;
    localparam logic [8:0] OpBra   = 9'b001100000;
    localparam logic [8:0] OpBrasl = 9'b001100010;
    localparam logic [8:0] OpBrz   = 9'b001000000;
    localparam logic [8:0] OpBrnz  = 9'b001000010;
    localparam logic [8:0] OpBrhz  = 9'b001000100;
    localparam logic [8:0] OpBrhnz = 9'b001000110;

    localparam logic [2:0] LockLoad = 3'(SQUASH_CYC);

    typedef struct packed {
        logic            valid;
        logic            mp;
        logic            taken;
        logic            we;
        logic [31:0]     link;
        logic [6:0]      dest;
        logic [PC_W-1:0] npc;
        logic [PC_W-1:0] pc;
    } rec_t;

    logic [PC_W-1:0] off;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] tgt;
    logic            known;
    logic            is_link;
    logic            is_abs;
    logic            taken;
    rec_t            in_rec;
    rec_t            out_rec;
    rec_t            stage_q [LAT];
    logic [2:0]      lock_q;
    logic [2:0]      lock_d;
    logic            out_mp;
    logic            kill;
    logic            accept;
    logic            unused_rt;

    // Only the preferred slot takes part in condition evaluation.
    assign unused_rt = ^rt[32:127];

    always_comb begin
        off     = PC_W'($signed({immediate16, 2'b00}));
        seq     = (PCin + PC_W'(8)) & ~PC_W'(7);
        known   = 1'b1;
        is_link = 1'b0;
        is_abs  = 1'b0;
        taken   = 1'b1;
        case (opcode9)
            OpBr:    taken = 1'b1;
            OpBrsl:  is_link = 1'b1;
            OpBra:   is_abs = 1'b1;
            OpBrasl: begin
                is_abs  = 1'b1;
                is_link = 1'b1;
            end
            OpBrz:   taken = (rt[0:31] == '0);
            OpBrnz:  taken = (rt[0:31] != '0);
            OpBrhz:  taken = (rt[16:31] == '0);
            OpBrhnz: taken = (rt[16:31] != '0);
            default: known = 1'b0;
        endcase

        if (!taken) begin
            tgt = seq;
        end else if (is_abs) begin
            tgt = off;
        end else begin
            tgt = PCin + off;
        end

        in_rec.valid = 1'b1;
        in_rec.taken = taken;
        in_rec.mp    = (predictIn != taken) || (predictPCin != tgt);
        in_rec.we    = is_link;
        in_rec.link  = is_link ? 32'(PCin + PC_W'(4)) : '0;
        in_rec.dest  = addr_rt;
        in_rec.npc   = tgt;
        in_rec.pc    = PCin;
    end

    assign out_rec = stage_q[LAT-1];
    assign out_mp  = out_rec.valid & out_rec.mp;
    // A presented mispredict kills every younger record, including the one entering now.
    assign kill    = flush | out_mp;
    assign accept  = in_valid & known & (lock_q == '0) & ~kill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else if (kill) begin
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= accept ? in_rec : '0;
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (out_mp) begin
            lock_d = LockLoad;
        end else if (lock_q != '0) begin
            lock_d = lock_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= '0;
            br_cnt <= '0;
            mp_cnt <= '0;
        end else begin
            lock_q <= lock_d;
            if (out_rec.valid && br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
            if (out_mp && mp_cnt != '1) mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        out_valid = out_rec.valid;
        pipe      = '0;
        PCpipe    = '0;
        if (out_rec.valid) begin
            pipe   = {out_rec.link, 96'd0, 3'd1, out_rec.we, out_rec.dest};
            PCpipe = {out_rec.npc, out_rec.taken, out_rec.pc, out_rec.mp};
        end
    end

endmodule

// File: tb/tb_branch_pipe.sv
// Bench for branch_pipe: a LAT=1 and a LAT=3/CNT_W=4 instance share stimulus and are
// checked every cycle against a due-time schedule model, plus directed literal checks.
module tb_branch_pipe;

    localparam int SQ = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [8:0]   opcode9;
    logic [15:0]  imm;
    logic [0:127] rt;
    logic [6:0]   addr_rt;
    logic [31:0]  pcin;
    logic         predict_in;
    logic [31:0]  predict_pc;
    logic         flush;

    logic [0:138] pipe1, pipe3;
    logic [0:65]  pcp1, pcp3;
    logic         ov1, ov3;
    logic [15:0]  br1, mp1;
    logic [3:0]   br3, mp3;

    always #5 clk = ~clk;

    branch_pipe #(.PC_W(32), .LAT(1), .SQUASH_CYC(SQ), .CNT_W(16)) u_lat1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode9(opcode9),
        .immediate16(imm), .rt(rt), .addr_rt(addr_rt), .PCin(pcin), .predictIn(predict_in),
        .predictPCin(predict_pc), .flush(flush), .pipe(pipe1), .PCpipe(pcp1),
        .out_valid(ov1), .br_cnt(br1), .mp_cnt(mp1)
    );

    branch_pipe #(.PC_W(32), .LAT(3), .SQUASH_CYC(SQ), .CNT_W(4)) u_lat3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .opcode9(opcode9),
        .immediate16(imm), .rt(rt), .addr_rt(addr_rt), .PCin(pcin), .predictIn(predict_in),
        .predictPCin(predict_pc), .flush(flush), .pipe(pipe3), .PCpipe(pcp3),
        .out_valid(ov3), .br_cnt(br3), .mp_cnt(mp3)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: what the unit must output for one instruction, straight from the rules.
    function automatic void calc(input logic [8:0] op, input logic [15:0] im,
                                 input logic [0:127] r, input logic [6:0] art,
                                 input logic [31:0] pc, input logic pin,
                                 input logic [31:0] ppc, output bit known,
                                 output logic [0:138] ep, output logic [0:65] epc,
                                 output bit emp);
        logic [31:0] off, seq, npc;
        bit lnk, tk, ab;
        off = {{14{im[15]}}, im, 2'b00};
        seq = (pc + 32'd8) & ~32'd7;
        lnk = 0; tk = 1; ab = 0; known = 1;
        case (op)
            9'b001100100: tk = 1;
            9'b001100110: lnk = 1;
            9'b001100000: ab = 1;
            9'b001100010: begin ab = 1; lnk = 1; end
            9'b001000000: tk = (r[0:31] == 32'd0);
            9'b001000010: tk = (r[0:31] != 32'd0);
            9'b001000100: tk = (r[16:31] == 16'd0);
            9'b001000110: tk = (r[16:31] != 16'd0);
            default:      known = 0;
        endcase
        npc = !tk ? seq : (ab ? off : pc + off);
        emp = (pin != tk) || (ppc != npc);
        ep = '0;
        if (lnk) ep[0:31] = pc + 32'd4;
        ep[128:130] = 3'd1;
        ep[131] = lnk;
        ep[132:138] = art;
        epc[0:31] = npc;
        epc[32] = tk;
        epc[33:64] = pc;
        epc[65] = emp;
    endfunction

    // Model: each instance keeps a schedule of records keyed by the cycle they are shown.
    typedef struct packed {
        logic         v;
        logic         mp;
        logic [0:138] p;
        logic [0:65]  pc;
    } rec_t;

    rec_t sched [2][8];
    int   lat  [2] = '{1, 3};
    int   lim  [2] = '{65535, 15};
    int   brc  [2];
    int   mpc  [2];
    int   lock [2];
    int   cyc = 0;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) sched[k][j] = '0;
            brc[k] = 0; mpc[k] = 0; lock[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit known, mp_in, acc;
        logic [0:138] ip;
        logic [0:65] ipc;
        rec_t pres;
        calc(opcode9, imm, rt, addr_rt, pcin, predict_in, predict_pc, known, ip, ipc, mp_in);
        for (int k = 0; k < 2; k++) begin
            pres = sched[k][cyc & 7];
            acc = in_valid && known && !flush && !(pres.v && pres.mp) && lock[k] == 0;
            if (pres.v) begin
                if (brc[k] < lim[k]) brc[k]++;
                if (pres.mp && mpc[k] < lim[k]) mpc[k]++;
            end
            if (pres.v && pres.mp) lock[k] = SQ;
            else if (lock[k] > 0) lock[k]--;
            sched[k][cyc & 7].v = 0;
            if (flush || (pres.v && pres.mp))
                for (int j = 0; j < 8; j++) sched[k][j].v = 0;
            if (acc) begin
                sched[k][(cyc + lat[k]) & 7].v  = 1;
                sched[k][(cyc + lat[k]) & 7].mp = mp_in;
                sched[k][(cyc + lat[k]) & 7].p  = ip;
                sched[k][(cyc + lat[k]) & 7].pc = ipc;
            end
        end
        cyc++;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                rec_t e;
                e = sched[k][cyc & 7];
                chk(k ? "ov3" : "ov1", k ? ov3 : ov1, e.v);
                chk(k ? "pipe3" : "pipe1", k ? pipe3 : pipe1, e.v ? e.p : '0);
                chk(k ? "pcpipe3" : "pcpipe1", k ? pcp3 : pcp1, e.v ? e.pc : '0);
                chk(k ? "br_cnt3" : "br_cnt1", k ? {12'd0, br3} : br1, brc[k]);
                chk(k ? "mp_cnt3" : "mp_cnt1", k ? {12'd0, mp3} : mp1, mpc[k]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic [8:0] op, input logic [15:0] im, input logic [31:0] w0,
                         input logic [6:0] art, input logic [31:0] pc, input logic pin,
                         input logic [31:0] ppc);
        in_valid = 1; opcode9 = op; imm = im; rt = {w0, 96'd0};
        addr_rt = art; pcin = pc; predict_in = pin; predict_pc = ppc;
    endtask

    logic [8:0]   ops [9];
    logic [0:138] uid_only;
    logic [8:0]   ovs;

    initial begin
        ops = '{9'b001100100, 9'b001100110, 9'b001100000, 9'b001100010, 9'b001000000,
                9'b001000010, 9'b001000100, 9'b001000110, 9'b001100101};
        uid_only = '0;
        uid_only[130] = 1'b1;
        in_valid = 0; opcode9 = '0; imm = '0; rt = '0; addr_rt = '0; pcin = '0;
        predict_in = 0; predict_pc = '0; flush = 0;
        model_reset();
        reset = 1;
        #1 reset = 0;
        #1;
        chk("reset_ov", ov1, 1'b0);
        chk("reset_pipe", pipe3, '0);
        chk("reset_pcpipe", pcp1, '0);
        chk("reset_br_cnt", br3, '0);
        @(negedge clk);
        reset = 1;
        chk_on = 1;

        // LAT=1 literal expectations
        drive(9'b001100100, 16'hFFFF, 32'd0, 7'd0, 32'h100, 1'b1, 32'hFC);
        step();
        chk("br_target", pcp1[0:31], 32'hFC);
        chk("br_taken", pcp1[32], 1'b1);
        chk("br_mp", pcp1[65], 1'b0);
        chk("br_pipe", pipe1, uid_only);
        drive(9'b001100110, 16'd4, 32'd0, 7'd5, 32'h200, 1'b0, 32'h204);
        step();
        chk("br_cnt_after_br", br1, 16'd1);
        chk("brsl_link", pipe1[0:31], 32'h204);
        chk("brsl_we", pipe1[131], 1'b1);
        chk("brsl_dest", pipe1[132:138], 7'd5);
        chk("brsl_target", pcp1[0:31], 32'h210);
        chk("brsl_mp", pcp1[65], 1'b1);
        in_valid = 0;
        step();
        chk("mp_cnt_after_brsl", mp1, 16'd1);
        repeat (2) step();
        drive(9'b001000010, 16'd5, 32'd0, 7'd0, 32'h104, 1'b0, 32'h108);
        step();
        chk("brnz_target", pcp1[0:31], 32'h108);
        chk("brnz_taken", pcp1[32], 1'b0);
        chk("brnz_mp", pcp1[65], 1'b0);
        drive(9'b001000100, 16'd2, 32'h00010000, 7'd0, 32'h300, 1'b1, 32'h308);
        step();
        chk("brhz_taken", pcp1[32], 1'b1);
        chk("brhz_target", pcp1[0:31], 32'h308);

        // asynchronous reset with records in flight
        drive(9'b001100100, 16'd1, 32'd0, 7'd3, 32'h500, 1'b1, 32'h504);
        repeat (3) step();
        #2;
        reset = 0;
        chk_on = 0;
        #1;
        chk("areset_ov1", ov1, 1'b0);
        chk("areset_ov3", ov3, 1'b0);
        chk("areset_pipe3", pipe3, '0);
        chk("areset_pcpipe3", pcp3, '0);
        chk("areset_br_cnt3", br3, '0);
        model_reset();
        in_valid = 0;
        @(negedge clk);
        reset = 1;
        chk_on = 1;

        // LAT=3 squash and lockout
        drive(9'b001100100, 16'd8, 32'd0, 7'd0, 32'h400, 1'b0, 32'h420);
        step();
        ovs[0] = ov3;
        drive(9'b001100100, 16'd1, 32'd0, 7'd0, 32'h500, 1'b1, 32'h504);
        for (int i = 1; i < 9; i++) begin
            if (i == 7) in_valid = 0;
            step();
            ovs[i] = ov3;
            if (i == 2) begin
                chk("lat3_mp_target", pcp3[0:31], 32'h420);
                chk("lat3_mp_flag", pcp3[65], 1'b1);
            end
        end
        chk("lat3_ov_seq", ovs, 9'b100000100);
        step();
        chk("lat3_br_cnt", br3, 4'd2);
        chk("lat3_mp_cnt", mp3, 4'd1);

        // flush with three records in flight
        drive(9'b001100100, 16'd1, 32'd0, 7'd0, 32'h500, 1'b1, 32'h504);
        repeat (3) step();
        flush = 1;
        step();
        ovs[0] = ov3;
        flush = 0;
        in_valid = 0;
        step();
        ovs[1] = ov3;
        step();
        ovs[2] = ov3;
        chk("flush_ov", ovs[2:0], 3'b000);
        chk("flush_br_cnt", br3, 4'd3);
        chk("flush_mp_cnt", mp3, 4'd1);

        // saturation of the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            drive(9'b001100000, 16'd16, 32'd0, 7'd0, 32'h600, 1'b0, 32'h40);
            step();
            in_valid = 0;
            repeat (5) step();
        end
        chk("sat_mp_cnt", mp3, 4'hF);
        chk("sat_br_cnt", br3, 4'hF);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit known, m;
            logic [0:138] ip;
            logic [0:65] ipc;
            in_valid = ($urandom_range(0, 9) < 7);
            opcode9 = ops[$urandom_range(0, 8)];
            imm = 16'($urandom);
            rt = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rt[0:31] = '0;
                1: rt[16:31] = '0;
                default: ;
            endcase
            addr_rt = 7'($urandom);
            pcin = $urandom;
            calc(opcode9, imm, rt, addr_rt, pcin, 1'b0, 32'd0, known, ip, ipc, m);
            predict_in = ipc[32];
            predict_pc = ipc[0:31];
            case ($urandom_range(0, 3))
                2: predict_in = ~ipc[32];
                3: predict_pc = $urandom;
                default: ;
            endcase
            flush = ($urandom_range(0, 99) < 3);
            step();
        end
        in_valid = 0;
        flush = 0;
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
